// File: rtl/credit_pkg.sv
// credit_pkg: shared limits and width helper for the credit receiver slice
package credit_pkg;
    localparam int MIN_MAX_CREDIT = 1;
    localparam int MIN_POP_CREDIT_MAX = 1;
    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction
endpackage

// File: rtl/credit_sat_counter.sv
// credit_sat_counter: up-by-N / down-by-1 counter with load and saturation at MAX
module credit_sat_counter #(
    parameter int W   = 4,
    parameter int NW  = 1,
    parameter int MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic [NW-1:0] inc,
    input  logic          dec,
    output logic [W-1:0]  count,
    output logic          ovf
);
    localparam int SW = ((W > NW) ? W : NW) + 1;
    logic [SW-1:0] sum;
    assign sum = SW'(count) + SW'(inc) - SW'(dec);
    assign ovf = !load && sum > SW'(MAX);
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else count <= load ? load_val : ovf ? W'(MAX) : sum[W-1:0];
endmodule

// File: rtl/credit_receiver_pool.sv
// credit_receiver_pool: receive-side credit pool returning one credit per cycle,
// with withhold, replenish, optional registered return and sticky error flags
module credit_receiver_pool
    import credit_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int MAX_CREDIT      = 8,
    parameter int POP_CREDIT_MAX  = 1,
    parameter int REG_PUSH_CREDIT = 0,
    localparam int CW = clog2_safe(MAX_CREDIT + 1),
    localparam int PW = clog2_safe(POP_CREDIT_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_sender_in_reset,
    output logic             push_receiver_in_reset,
    input  logic             push_credit_stall,
    output logic             push_credit,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    output logic [WIDTH-1:0] pop_data,
    input  logic [PW-1:0]    pop_credit,
    input  logic [CW-1:0]    credit_initial,
    input  logic [CW-1:0]    credit_withhold,
    output logic [CW-1:0]    credit_count,
    output logic [CW-1:0]    credit_available,
    output logic             credit_overflow,
    output logic             protocol_error
);
    if (MAX_CREDIT < MIN_MAX_CREDIT) begin : g_bad_max
        $error("MAX_CREDIT must be >= 1");
    end
    if (POP_CREDIT_MAX < MIN_POP_CREDIT_MAX) begin : g_bad_pop
        $error("POP_CREDIT_MAX must be >= 1");
    end
    logic in_reset, issue, pc_q, out_dec, bad_beat, pool_ovf, unused_out_ovf;
    logic [CW-1:0] outstanding;
    assign in_reset = push_receiver_in_reset | push_sender_in_reset;
    assign credit_available = (credit_count > credit_withhold) ? credit_count - credit_withhold : '0;
    assign issue = !in_reset && !push_credit_stall && credit_available != '0;
    // a registered credit still in the flop when a reset starts is dropped with the rest
    assign push_credit = (REG_PUSH_CREDIT != 0) ? pc_q && !in_reset : issue;
    assign pop_valid = push_valid && !in_reset;
    assign pop_data = push_data;
    assign bad_beat = !in_reset && push_valid && outstanding == '0 && !push_credit;
    assign out_dec = push_valid && (outstanding != '0 || push_credit);
    credit_sat_counter #(.W(CW), .NW(PW), .MAX(MAX_CREDIT)) u_pool (
        .clk      (clk),
        .rst      (rst),
        .load     (in_reset),
        .load_val (credit_initial),
        .inc      (pop_credit),
        .dec      (issue),
        .count    (credit_count),
        .ovf      (pool_ovf)
    );
    credit_sat_counter #(.W(CW), .NW(1), .MAX((1 << CW) - 1)) u_outstanding (
        .clk      (clk),
        .rst      (rst),
        .load     (in_reset),
        .load_val ('0),
        .inc      (push_credit),
        .dec      (out_dec),
        .count    (outstanding),
        .ovf      (unused_out_ovf)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            push_receiver_in_reset <= 1'b1;
            pc_q <= 1'b0;
            credit_overflow <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            push_receiver_in_reset <= 1'b0;
            pc_q <= issue;
            credit_overflow <= credit_overflow | pool_ovf;
            protocol_error <= protocol_error | bad_beat;
        end
    always @(posedge clk)
        if (rst) assert (pop_credit <= PW'(POP_CREDIT_MAX));
endmodule

// File: tb/tb_credit_receiver_pool.sv
// tb_credit_receiver_pool: directed and random stimulus on combinational and registered
// credit-return variants, checked against a per-cycle integer model of the pool rules
module tb_credit_receiver_pool;
    localparam int MAXC = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sir = 1'b0, stall = 1'b0, pv = 1'b0;
    logic [7:0] pd = '0;
    logic [0:0] pop = '0;
    logic [3:0] init = '0, wh = '0;
    logic rir_o [2];
    logic pc_o [2];
    logic pvo_o [2];
    logic [7:0] pdo_o [2];
    logic [3:0] cc_o [2];
    logic [3:0] ca_o [2];
    logic ovf_o [2];
    logic perr_o [2];
    int n_checks = 0, n_fail = 0;
    int m_pool [2], m_outst [2];
    bit m_ovf [2], m_perr [2], m_q [2];
    bit m_rir;
    bit s_pc0, s_pv0;
    logic [7:0] s_pd0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : g_dut
        credit_receiver_pool #(.WIDTH(8), .MAX_CREDIT(MAXC), .POP_CREDIT_MAX(1), .REG_PUSH_CREDIT(g)) u_dut (
            .clk                    (clk),
            .rst                    (rst),
            .push_sender_in_reset   (sir),
            .push_receiver_in_reset (rir_o[g]),
            .push_credit_stall      (stall),
            .push_credit            (pc_o[g]),
            .push_valid             (pv),
            .push_data              (pd),
            .pop_valid              (pvo_o[g]),
            .pop_data               (pdo_o[g]),
            .pop_credit             (pop),
            .credit_initial         (init),
            .credit_withhold        (wh),
            .credit_count           (cc_o[g]),
            .credit_available       (ca_o[g]),
            .credit_overflow        (ovf_o[g]),
            .protocol_error         (perr_o[g])
        );
    end
    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step();
        bit ir, iss, pc;
        int av, s;
        @(negedge clk);
        s_pc0 = pc_o[0];
        s_pv0 = pvo_o[0];
        s_pd0 = pdo_o[0];
        for (int k = 0; k < 2; k++) begin
            ir = m_rir || sir;
            av = (m_pool[k] > int'(wh)) ? m_pool[k] - int'(wh) : 0;
            iss = !ir && !stall && av != 0;
            pc = (k == 0) ? iss : (m_q[k] && !ir);
            check($sformatf("push_credit[%0d]", k), pc_o[k], pc);
            check($sformatf("credit_count[%0d]", k), cc_o[k], m_pool[k]);
            check($sformatf("credit_available[%0d]", k), ca_o[k], av);
            check($sformatf("pop_valid[%0d]", k), pvo_o[k], pv && !ir);
            check($sformatf("pop_data[%0d]", k), pdo_o[k], pd);
            check($sformatf("overflow[%0d]", k), ovf_o[k], m_ovf[k]);
            check($sformatf("protocol_error[%0d]", k), perr_o[k], m_perr[k]);
            check($sformatf("rx_in_reset[%0d]", k), rir_o[k], m_rir);
            if (rst) begin
                if (ir) begin
                    m_pool[k] = int'(init);
                    m_outst[k] = 0;
                end else begin
                    s = m_pool[k] + int'(pop) - int'(iss);
                    if (s > MAXC) begin
                        m_pool[k] = MAXC;
                        m_ovf[k] = 1;
                    end else m_pool[k] = s;
                    if (pv && m_outst[k] == 0 && !pc) m_perr[k] = 1;
                    else m_outst[k] = m_outst[k] + int'(pc) - int'(pv);
                end
                m_q[k] = iss;
            end
        end
        if (rst) m_rir = 0;
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset(input int ini, input int w);
        rst = 1'b0; sir = 0; stall = 0; pv = 0; pop = '0;
        init = 4'(ini); wh = 4'(w);
        m_rir = 1;
        for (int k = 0; k < 2; k++) begin
            m_pool[k] = 0; m_outst[k] = 0; m_ovf[k] = 0; m_perr[k] = 0; m_q[k] = 0;
        end
        step();
        step();
        rst = 1'b1;
    endtask
    initial begin
        int n;
        #1;
        do_reset(4, 0);
        n = 0;
        repeat (8) begin step(); n += int'(s_pc0); end
        check("t1_credits", n, 4);
        check("t1_count_end", cc_o[0], 0);
        do_reset(4, 2);
        n = 0;
        repeat (8) begin step(); n += int'(s_pc0); end
        check("t2_withheld", n, 2);
        wh = 0;
        n = 0;
        repeat (6) begin step(); n += int'(s_pc0); end
        check("t2_released", n, 2);
        do_reset(3, 3);
        repeat (3) step();
        wh = 0; pop = 1'b1;
        n = 0;
        repeat (4) begin step(); n += int'(s_pc0); end
        check("t3_credits", n, 4);
        check("t3_count", cc_o[0], 3);
        do_reset(8, 0);
        stall = 1;
        step();
        pop = 1'b1;
        repeat (3) step();
        check("t4_overflow", ovf_o[0], 1);
        check("t4_count", cc_o[0], 8);
        pop = 1'b0; stall = 0;
        repeat (10) step();
        check("t4_sticky", ovf_o[1], 1);
        do_reset(2, 0);
        step();
        check("t4_cleared", ovf_o[0], 0);
        do_reset(4, 0);
        stall = 1;
        repeat (2) step();
        pv = 1; pd = 8'hA5;
        step();
        check("t5_pop_data", s_pd0, 8'hA5);
        check("t5_pop_valid", s_pv0, 1);
        pv = 0;
        step();
        check("t5_protocol", perr_o[0], 1);
        do_reset(4, 0);
        repeat (7) step();
        repeat (4) begin pv = 1; pd = 8'($urandom); step(); end
        pv = 0;
        step();
        check("t5_clean0", perr_o[0], 0);
        check("t5_clean1", perr_o[1], 0);
        do_reset(5, 0);
        repeat (4) step();
        stall = 1;
        step();
        check("t6_count", cc_o[0], 2);
        sir = 1; pv = 1;
        step();
        check("t6_pc_gated", s_pc0, 0);
        check("t6_pv_gated", s_pv0, 0);
        sir = 0; pv = 0; stall = 0;
        step();
        check("t6_reload", s_pc0, 1);
        repeat (400) begin
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, MAXC), $urandom_range(0, 3));
            sir = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 3) == 0);
            pop = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) wh = 4'($urandom_range(0, MAXC));
            pv = (m_outst[0] > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            pd = 8'($urandom);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
